// File: rtl/doorlock_pkg.sv
// Shared types and sizing for the door-lock master authentication slice.
package doorlock_pkg;

  localparam int PW_W       = 128;
  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_UNLOCK,
    ST_LOCKOUT,
    ST_PROG
  } state_t;

  function automatic logic [PW_W-1:0] push_digit(input logic [PW_W-1:0] buf_in,
                                                 input logic [DIGIT_W-1:0] d);
    return {buf_in[PW_W-DIGIT_W-1:0], d};
  endfunction

endpackage

// File: rtl/digit_shift_buffer.sv
// Keypad entry buffer: 128-bit digit shift register with a saturating digit counter.
module digit_shift_buffer
  import doorlock_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [PW_W-1:0]    o_data,
  output logic [CNT_W-1:0]   o_count
);

  logic [PW_W-1:0]  r_data;
  logic [CNT_W-1:0] r_count;
  logic             w_full;

  assign w_full = (r_count >= CNT_W'(MAX_DIGITS));

  // Priority: clear over fresh load over shift; a full buffer drops further digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_data  <= {{(PW_W-DIGIT_W){1'b0}}, i_digit};
      r_count <= CNT_W'(1);
    end else if (i_shift && !w_full) begin
      r_data  <= push_digit(r_data, i_digit);
      r_count <= r_count + 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/master_auth_ctrl.sv
// Master password authentication FSM with fail counting, unlock/lockout timing.
// Define MASTER_PROG_EN to allow reprogramming the master password from UNLOCK.
module master_auth_ctrl
  import doorlock_pkg::*;
#(
  parameter logic [PW_W-1:0] MASTER_INIT    = 128'h0,
  parameter int              MAX_FAIL       = 3,
  parameter int              UNLOCK_CYCLES  = 1000,
  parameter int              LOCKOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       clear,
  input  logic       confirm,
  input  logic       prog_req,
  output logic       unlocked,
  output logic       locked_out,
  output logic       fail_pulse,
  output logic [5:0] digit_count,
  output logic       prog_mode
);

  state_t           r_state;
  state_t           w_next;
  logic [PW_W-1:0]  w_buf;
  logic [PW_W-1:0]  w_master;
  logic [CNT_W-1:0] w_count;
  logic [3:0]       r_fail_cnt;
  logic [31:0]      r_timer;
  logic             w_match;
  logic             w_fail_limit;
  logic             w_timer_done;
  logic             w_buf_clear;
  logic             w_buf_load;
  logic             w_buf_shift;
  logic             w_master_we;
  logic             w_prog_req;

  digit_shift_buffer u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_buf_clear),
    .i_load  (w_buf_load),
    .i_shift (w_buf_shift),
    .i_digit (digit),
    .o_data  (w_buf),
    .o_count (w_count)
  );

`ifdef MASTER_PROG_EN
  logic [PW_W-1:0] r_master;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_master <= MASTER_INIT;
    else if (w_master_we)
      r_master <= w_buf;
  end

  assign w_master   = r_master;
  assign w_prog_req = prog_req;
`else
  logic w_unused;

  assign w_unused   = prog_req ^ w_master_we;
  assign w_master   = MASTER_INIT;
  assign w_prog_req = 1'b0;
`endif

  assign w_match      = (w_buf == w_master);
  assign w_fail_limit = ((int'(r_fail_cnt) + 1) >= MAX_FAIL);
  assign w_timer_done = (r_timer == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_buf_clear = 1'b0;
    w_buf_load  = 1'b0;
    w_buf_shift = 1'b0;
    w_master_we = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (digit_valid) begin
          w_buf_load = 1'b1;
          w_next     = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (clear) begin
          w_buf_clear = 1'b1;
          w_next      = ST_IDLE;
        end else if (confirm) begin
          w_next = ST_CHECK;
        end else if (digit_valid) begin
          w_buf_shift = 1'b1;
        end
      end
      ST_CHECK: begin
        w_buf_clear = 1'b1;
        if (w_match)
          w_next = ST_UNLOCK;
        else if (w_fail_limit)
          w_next = ST_LOCKOUT;
        else
          w_next = ST_IDLE;
      end
      ST_UNLOCK: begin
        if (w_prog_req) begin
          w_buf_clear = 1'b1;
          w_next      = ST_PROG;
        end else if (w_timer_done) begin
          w_next = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (w_timer_done)
          w_next = ST_IDLE;
      end
      ST_PROG: begin
        if (clear) begin
          w_buf_clear = 1'b1;
          w_next      = ST_IDLE;
        end else if (confirm) begin
          w_buf_clear = 1'b1;
          w_master_we = (w_count == CNT_W'(MAX_DIGITS));
          w_next      = ST_IDLE;
        end else if (digit_valid) begin
          w_buf_shift = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Timer is armed during CHECK so UNLOCK/LOCKOUT last exactly N cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_timer <= '0;
    else if (r_state == ST_CHECK)
      r_timer <= w_match ? 32'(UNLOCK_CYCLES - 1) : 32'(LOCKOUT_CYCLES - 1);
    else if (!w_timer_done)
      r_timer <= r_timer - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_fail_cnt <= '0;
    else if (r_state == ST_CHECK)
      r_fail_cnt <= w_match ? 4'd0 : r_fail_cnt + 4'd1;
    else if (r_state == ST_LOCKOUT && w_timer_done)
      r_fail_cnt <= '0;
  end

  always_comb begin
    unlocked    = (r_state == ST_UNLOCK);
    locked_out  = (r_state == ST_LOCKOUT);
    fail_pulse  = (r_state == ST_CHECK) && !w_match;
    digit_count = w_count;
`ifdef MASTER_PROG_EN
    prog_mode   = (r_state == ST_PROG);
`else
    prog_mode   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_master_auth_ctrl.sv
// Randomized self-checking bench for master_auth_ctrl against a digit-queue reference model.
module tb_master_auth_ctrl;

  localparam logic [127:0] MI = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam int MF = 3;
  localparam int UC = 40;
  localparam int LC = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       clear = 1'b0;
  logic       confirm = 1'b0;
  logic       prog_req = 1'b0;
  logic       unlocked, locked_out, fail_pulse, prog_mode;
  logic [5:0] digit_count;

  int n_checks = 0;
  int n_fail   = 0;

  int           m_digits[$];
  int           m_fails  = 0;
  int           m_pulses = 0;
  int           seen_pulses = 0;
  logic [127:0] m_master = MI;
  logic [127:0] code_v   = MI;

  master_auth_ctrl #(
    .MASTER_INIT    (MI),
    .MAX_FAIL       (MF),
    .UNLOCK_CYCLES  (UC),
    .LOCKOUT_CYCLES (LC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_valid (digit_valid),
    .digit       (digit),
    .clear       (clear),
    .confirm     (confirm),
    .prog_req    (prog_req),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .fail_pulse  (fail_pulse),
    .digit_count (digit_count),
    .prog_mode   (prog_mode)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && fail_pulse === 1'b1) seen_pulses++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int m_count();
    return (m_digits.size() > 32) ? 32 : m_digits.size();
  endfunction

  // Entered code as a number: first 32 digits, most significant first.
  function automatic logic [127:0] m_value();
    logic [127:0] v = '0;
    for (int i = 0; i < m_digits.size() && i < 32; i++)
      v = v * 16 + 128'(m_digits[i]);
    return v;
  endfunction

  task automatic press(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
    m_digits.push_back(int'(d));
    chk("digit_count", 6'(digit_count), 128'(m_count()));
  endtask

  task automatic press_code(input logic [127:0] c, input int n);
    logic [127:0] v = c;
    for (int i = 0; i < n; i++)
      press(v[127 - 4*i -: 4]);
  endtask

  task automatic measure_unlock;
    int cnt = 0;
    chk("unlock_start", unlocked, 1);
    while (unlocked === 1'b1 && cnt < UC * 4) begin
      cnt++;
      tick();
    end
    chk("unlock_len", cnt, UC);
  endtask

  task automatic measure_lockout;
    int cnt = 0;
    chk("lockout_start", locked_out, 1);
    while (locked_out === 1'b1 && cnt < LC * 4) begin
      cnt++;
      chk("lockout_count", digit_count, 0);
      digit_valid = 1'($urandom);
      digit       = 4'($urandom);
      confirm     = 1'($urandom);
      clear       = 1'($urandom);
      tick();
      digit_valid = 1'b0;
      confirm     = 1'b0;
      clear       = 1'b0;
    end
    chk("lockout_len", cnt, LC);
  endtask

  task automatic submit;
    logic match;
    match = (m_value() == m_master);
    m_digits.delete();
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    chk("fail_pulse", fail_pulse, !match);
    chk("unlock_early", unlocked, 0);
    tick();
    if (match) begin
      m_fails = 0;
      measure_unlock();
    end else begin
      m_pulses++;
      m_fails++;
      if (m_fails == MF) begin
        m_fails = 0;
        measure_lockout();
      end else begin
        chk("no_lockout", locked_out, 0);
      end
    end
    chk("count_after", digit_count, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_unlocked", unlocked, 0);
    chk("rst_locked", locked_out, 0);
    chk("rst_fail", fail_pulse, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_prog", prog_mode, 0);
    rst_n = 1'b1;
    tick();

    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    chk("idle_confirm_fail", fail_pulse, 0);
    tick();
    chk("idle_confirm_unlock", unlocked, 0);

    press_code(MI, 32);
    submit();

    press_code(MI, 32);
    for (int i = 0; i < 3; i++) press(4'($urandom));
    submit();

    for (int i = 0; i < 3; i++) press(4'($urandom));
    clear   = 1'b1;
    confirm = 1'b1;
    tick();
    clear   = 1'b0;
    confirm = 1'b0;
    m_digits.delete();
    chk("clr_cfm_count", digit_count, 0);
    chk("clr_cfm_fail", fail_pulse, 0);
    tick();
    chk("clr_cfm_fail2", fail_pulse, 0);
    chk("clr_cfm_unlock", unlocked, 0);

    for (int k = 0; k < 3; k++) begin
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      submit();
    end

    press(4'd9); submit();
    press(4'd9); submit();
    press_code(MI, 32); submit();
    press(4'd7); submit();
    press(4'd7); submit();
    press_code(MI, 32); submit();

    press(4'd5); submit();
    press(4'd5); submit();
    press(4'd5);
    m_digits.delete();
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    m_pulses++;
    tick();
    chk("lo_before_rst", locked_out, 1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_locked", locked_out, 0);
    chk("async_rst_count", digit_count, 0);
    tick();
    rst_n = 1'b1;
    m_fails = 0;
    tick();
    press(4'd6); submit();
    press(4'd6); submit();
    press_code(MI, 32); submit();

`ifdef MASTER_PROG_EN
    press_code(MI, 32);
    m_digits.delete();
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick();
    chk("prog_unlock", unlocked, 1);
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    chk("prog_mode_on", prog_mode, 1);
    chk("prog_unlock_off", unlocked, 0);
    chk("prog_count", digit_count, 0);
    for (int i = 0; i < 32; i++) press(4'hA);
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    m_master = {32{4'hA}};
    m_digits.delete();
    chk("prog_mode_off", prog_mode, 0);
    chk("prog_count_after", digit_count, 0);
    press_code(MI, 32); submit();
    press_code({32{4'hA}}, 32); submit();
`else
    prog_req = 1'b1;
    press_code(MI, 32);
    submit();
    chk("prog_ignored", prog_mode, 0);
    prog_req = 1'b0;
`endif

    for (int it = 0; it < 30; it++) begin
      int len;
      if ($urandom_range(0, 2) == 0) begin
        len = 32 + int'($urandom_range(0, 3));
        code_v = m_master;
        press_code(code_v, 32);
        for (int i = 32; i < len; i++) press(4'($urandom));
      end else begin
        len = int'($urandom_range(1, 35));
        for (int i = 0; i < len; i++) press(4'($urandom));
      end
      if ($urandom_range(0, 4) == 0) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_digits.delete();
        chk("rand_clear", digit_count, 0);
      end else begin
        submit();
      end
    end

    repeat (2) tick();
    chk("pulse_total", seen_pulses, m_pulses);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/master_auth_ctrl.md
MASTER_AUTH_CTRL -- requirements
Module: master_auth_ctrl

Interface
REQ-001 SHALL have parameter MASTER_INIT, default 128'h0, giving the reset value of the stored master password.
REQ-002 SHALL have parameter MAX_FAIL, default 3, giving the consecutive failures that trigger lockout (range 1..15).
REQ-003 SHALL have parameter UNLOCK_CYCLES, default 1000, giving the unlock hold time in clocks.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 5000, giving the lockout time in clocks.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port digit_valid, input, 1 bit: one-cycle keypad digit strobe.
REQ-008 SHALL have port digit, input, 4 bits: keypad digit, sampled when digit_valid=1.
REQ-009 SHALL have port clear, input, 1 bit: discards the current entry.
REQ-010 SHALL have port confirm, input, 1 bit: one-cycle request to check the entry.
REQ-011 SHALL have port prog_req, input, 1 bit: request to reprogram the master password.
REQ-012 SHALL have port unlocked, output, 1 bit: door release.
REQ-013 SHALL have port locked_out, output, 1 bit: lockout active.
REQ-014 SHALL have port fail_pulse, output, 1 bit: one-cycle pulse per rejected attempt.
REQ-015 SHALL have port digit_count, output, 6 bits: digits in the entry buffer (0..32).
REQ-016 SHALL have port prog_mode, output, 1 bit: reprogramming in progress.

Function
REQ-017 SHALL implement FSM states IDLE, ENTRY, CHECK, UNLOCK, LOCKOUT, PROG.
REQ-018 In IDLE, digit_valid SHALL clear the 128-bit buffer, load the digit into bits [3:0], set digit_count=1 and move to ENTRY.
REQ-019 In ENTRY/PROG, digit_valid SHALL shift the buffer left 4 bits, insert the digit at [3:0] and increment digit_count; at 32 further digits are ignored (no wrap).
REQ-020 In ENTRY, clear SHALL zero the buffer and digit_count and return to IDLE; clear has priority over a simultaneous digit_valid or confirm.
REQ-021 In ENTRY, confirm SHALL go to CHECK; confirm in IDLE (digit_count=0) is ignored; confirm has priority over a simultaneous digit_valid.
REQ-022 CHECK SHALL last exactly one cycle and compare the full 128-bit buffer with the stored master password (short entries are zero-padded at the top).
REQ-023 On a match, the FSM SHALL enter UNLOCK with fail counter = 0; unlocked is asserted 2 cycles after confirm and held for exactly UNLOCK_CYCLES cycles, then the FSM returns to IDLE.
REQ-024 On a mismatch, fail_pulse SHALL be asserted for one cycle and the fail counter incremented; if the counter reaches MAX_FAIL the FSM enters LOCKOUT, otherwise IDLE.
REQ-025 LOCKOUT SHALL assert locked_out for exactly LOCKOUT_CYCLES cycles, then clear the fail counter and return to IDLE.
REQ-026 In CHECK, UNLOCK and LOCKOUT, digit_valid, confirm and clear SHALL be ignored.
REQ-027 The buffer and digit_count SHALL be zeroed on every exit from CHECK and from PROG.

Reset
REQ-028 While rst_n=0, the FSM SHALL be IDLE, the buffer, digit_count and fail counter 0, the master register MASTER_INIT, and all outputs 0.
REQ-029 Reset asserted mid-UNLOCK or mid-LOCKOUT SHALL drop unlocked/locked_out immediately (asynchronously).

Configuration
REQ-030 With MASTER_PROG_EN defined, prog_req=1 in UNLOCK SHALL enter PROG with prog_mode=1 and an empty buffer; confirm with digit_count=32 writes the buffer into the master register and returns to IDLE; confirm with fewer digits, or clear, exits to IDLE without writing.
REQ-031 Without MASTER_PROG_EN, prog_req SHALL be ignored, PROG is unreachable, prog_mode is tied to 0, and the master register is the constant MASTER_INIT.

Structure
REQ-032 The FSM state enum, PW_W=128, DIGIT_W=4 and MAX_DIGITS=32 SHALL live in a shared package doorlock_pkg.
REQ-033 The buffer and digit counter SHALL be a sub-module digit_shift_buffer; the FSM, timer, fail counter and comparison stay in master_auth_ctrl.

Verification
REQ-034 Enter 32 digits matching MASTER_INIT=128'h0123...CDEF, then confirm -> unlocked=1 two cycles later for exactly UNLOCK_CYCLES cycles; fail counter 0.
REQ-035 Three wrong 4-digit entries with MAX_FAIL=3 -> three fail_pulse pulses, then locked_out=1 for LOCKOUT_CYCLES; digits during lockout leave digit_count=0.
REQ-036 35 digits then confirm -> digit_count saturates at 32; comparison uses the first 32 digits.
REQ-037 Same-cycle clear and confirm in ENTRY -> back to IDLE, no fail_pulse, digit_count=0.
REQ-038 With MASTER_PROG_EN: unlock, prog_req, 32 digits of 'A', confirm -> a subsequent 'A'x32 entry unlocks and the old code fails.
REQ-039 rst_n pulsed low mid-LOCKOUT -> locked_out=0 immediately; fail counter 0 after release.
